acc_dispatcher: RTL and testbench

- Sits between the CVA6 CVXIF-style coprocessor port and up to NR_ACC custom accelerator lanes.
- Decodes each offloaded instruction and either accepts or rejects it in the same cycle.
- Dispatches accepted instructions to the selected lane and tracks them in a DEPTH-entry reorder buffer (ROB).
- Returns results to the core strictly in issue order; flush_i discards all speculative work.

---
 rtl/acc_dispatcher.sv | 190 +++++++++++++++++++
 tb/tb_acc_dispatcher.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_dispatcher.sv
// acc_dispatcher: CVXIF-style offload front end that routes custom-opcode instructions to accelerator lanes
// and returns their results in issue order through a small reorder buffer.
`default_nettype none

module acc_dispatcher #(
   parameter int NR_ACC = 4,
   parameter int XLEN   = 64,
   parameter int ID_W   = 3,
   parameter int DEPTH  = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     issue_valid_i,
   output logic                     issue_ready_o,
   input  logic [31:0]              issue_instr_i,
   input  logic [XLEN-1:0]          issue_rs1_i,
   input  logic [XLEN-1:0]          issue_rs2_i,
   input  logic [ID_W-1:0]          issue_id_i,
   output logic                     issue_accept_o,
   output logic [NR_ACC-1:0]        acc_req_valid_o,
   input  logic [NR_ACC-1:0]        acc_req_ready_i,
   output logic [31:0]              acc_req_instr_o,
   output logic [XLEN-1:0]          acc_req_rs1_o,
   output logic [XLEN-1:0]          acc_req_rs2_o,
   input  logic [NR_ACC-1:0]        acc_resp_valid_i,
   input  logic [NR_ACC*XLEN-1:0]   acc_resp_data_i,
   output logic [NR_ACC-1:0]        acc_resp_ready_o,
   output logic                     result_valid_o,
   input  logic                     result_ready_i,
   output logic [ID_W-1:0]          result_id_o,
   output logic [XLEN-1:0]          result_data_o,
   output logic                     result_we_o,
   input  logic                     flush_i,
   output logic                     busy_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] rob_valid;
   logic [DEPTH-1:0] rob_done;
   logic [DEPTH-1:0] rob_we;
   logic [2:0]       rob_lane [DEPTH];
   logic [ID_W-1:0]  rob_id   [DEPTH];
   logic [XLEN-1:0]  rob_data [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [CW-1:0]    count;
   logic [CW-1:0]    drop_cnt [NR_ACC];

   logic              accept;
   logic [2:0]        lane;
   logic              rob_full;
   logic              lane_ready;
   logic              issue_hs;
   logic              pop;
   logic              drops_pending;
   logic [NR_ACC-1:0] resp_hit;
   logic [NR_ACC-1:0] resp_drop;
   logic [PW-1:0]     resp_idx [NR_ACC];
   logic [CW-1:0]     pending  [NR_ACC];

   assign acc_req_instr_o  = issue_instr_i;
   assign acc_req_rs1_o    = issue_rs1_i;
   assign acc_req_rs2_o    = issue_rs2_i;
   assign acc_resp_ready_o = '1;
   assign rob_full         = (count == CW'(DEPTH));
   assign issue_accept_o   = accept;

   always_comb begin
      lane       = issue_instr_i[14:12];
      accept     = (issue_instr_i[6:0] == 7'h0B) && (32'(lane) < NR_ACC);
      lane_ready = 1'b0;
      acc_req_valid_o = '0;
      for (int l = 0; l < NR_ACC; l++) begin
         if (lane == 3'(l)) begin
            lane_ready         = acc_req_ready_i[l];
            acc_req_valid_o[l] = issue_valid_i && accept && !rob_full && !flush_i;
         end
      end
      issue_ready_o = accept ? (!rob_full && lane_ready && !flush_i) : 1'b1;
      issue_hs      = issue_valid_i && accept && issue_ready_o;
   end

   // Each lane answers in its own order, so a response belongs to the oldest open entry of that lane.
   always_comb begin
      logic [PW-1:0] idx;
      idx = '0;
      drops_pending = 1'b0;
      for (int l = 0; l < NR_ACC; l++) begin
         resp_hit[l]  = 1'b0;
         resp_drop[l] = 1'b0;
         resp_idx[l]  = '0;
         pending[l]   = '0;
         if (drop_cnt[l] != '0)
            drops_pending = 1'b1;
         if (acc_resp_valid_i[l]) begin
            if (drop_cnt[l] != '0) begin
               resp_drop[l] = 1'b1;
            end else begin
               for (int k = 0; k < DEPTH; k++) begin
                  idx = head + PW'(k);
                  if (!resp_hit[l] && rob_valid[idx] && !rob_done[idx] && rob_lane[idx] == 3'(l)) begin
                     resp_hit[l] = 1'b1;
                     resp_idx[l] = idx;
                  end
               end
            end
         end
         for (int k = 0; k < DEPTH; k++) begin
            if (rob_valid[k] && !rob_done[k] && rob_lane[k] == 3'(l))
               pending[l] = pending[l] + CW'(1);
         end
      end
   end

   assign pop    = rob_valid[head] && rob_done[head] && (!result_valid_o || result_ready_i) && !flush_i;
   assign busy_o = (count != '0) || drops_pending;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         rob_valid      <= '0;
         rob_done       <= '0;
         result_valid_o <= 1'b0;
         result_id_o    <= '0;
         result_data_o  <= '0;
         result_we_o    <= 1'b0;
         for (int l = 0; l < NR_ACC; l++)
            drop_cnt[l] <= '0;
      end else begin
         if (result_valid_o && result_ready_i)
            result_valid_o <= 1'b0;
         if (pop) begin
            result_valid_o <= 1'b1;
            result_id_o    <= rob_id[head];
            result_data_o  <= rob_data[head];
            result_we_o    <= rob_we[head];
         end
         for (int l = 0; l < NR_ACC; l++) begin
            if (resp_hit[l]) begin
               rob_done[resp_idx[l]] <= 1'b1;
               rob_data[resp_idx[l]] <= acc_resp_data_i[l*XLEN +: XLEN];
            end
            // Work killed by a flush still comes back from the lane and must be swallowed.
            if (flush_i)
               drop_cnt[l] <= drop_cnt[l] - CW'(resp_drop[l]) + pending[l] - CW'(resp_hit[l]);
            else if (resp_drop[l])
               drop_cnt[l] <= drop_cnt[l] - CW'(1);
         end
         if (flush_i) begin
            rob_valid <= '0;
            rob_done  <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
         end else begin
            if (pop) begin
               rob_valid[head] <= 1'b0;
               head            <= head + PW'(1);
            end
            if (issue_hs) begin
               rob_valid[tail] <= 1'b1;
               rob_done[tail]  <= 1'b0;
               rob_we[tail]    <= (issue_instr_i[11:7] != 5'd0);
               rob_lane[tail]  <= lane;
               rob_id[tail]    <= issue_id_i;
               tail            <= tail + PW'(1);
            end
            count <= count + CW'(issue_hs) - CW'(pop);
         end
      end
   end

`ifndef SYNTHESIS
   logic rst_q;
   always_ff @(posedge clk_i) begin
      rst_q <= rst_i;
      if (!rst_i && !rst_q) begin
         for (int l = 0; l < NR_ACC; l++)
            assert (!(acc_resp_valid_i[l] && !resp_drop[l] && !resp_hit[l]));
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_acc_dispatcher.sv
// tb_acc_dispatcher: directed stimulus with a result scoreboard checked by an independent monitor.
`default_nettype none

module tb_acc_dispatcher;

   localparam int NR_ACC = 4;
   localparam int XLEN   = 64;
   localparam int ID_W   = 3;
   localparam int DEPTH  = 4;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [XLEN-1:0] data;
      logic            we;
   } exp_t;

   logic                   clk_i = 1'b0;
   logic                   rst_i;
   logic                   issue_valid_i;
   logic                   issue_ready_o;
   logic [31:0]            issue_instr_i;
   logic [XLEN-1:0]        issue_rs1_i;
   logic [XLEN-1:0]        issue_rs2_i;
   logic [ID_W-1:0]        issue_id_i;
   logic                   issue_accept_o;
   logic [NR_ACC-1:0]      acc_req_valid_o;
   logic [NR_ACC-1:0]      acc_req_ready_i;
   logic [31:0]            acc_req_instr_o;
   logic [XLEN-1:0]        acc_req_rs1_o;
   logic [XLEN-1:0]        acc_req_rs2_o;
   logic [NR_ACC-1:0]      acc_resp_valid_i;
   logic [NR_ACC*XLEN-1:0] acc_resp_data_i;
   logic [NR_ACC-1:0]      acc_resp_ready_o;
   logic                   result_valid_o;
   logic                   result_ready_i;
   logic [ID_W-1:0]        result_id_o;
   logic [XLEN-1:0]        result_data_o;
   logic                   result_we_o;
   logic                   flush_i;
   logic                   busy_o;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   acc_dispatcher #(.NR_ACC(NR_ACC), .XLEN(XLEN), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .issue_instr_i(issue_instr_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
      .issue_id_i(issue_id_i), .issue_accept_o(issue_accept_o),
      .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
      .acc_req_instr_o(acc_req_instr_o), .acc_req_rs1_o(acc_req_rs1_o), .acc_req_rs2_o(acc_req_rs2_o),
      .acc_resp_valid_i(acc_resp_valid_i), .acc_resp_data_i(acc_resp_data_i),
      .acc_resp_ready_o(acc_resp_ready_o),
      .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
      .result_id_o(result_id_o), .result_data_o(result_data_o), .result_we_o(result_we_o),
      .flush_i(flush_i), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every result handshake must match the oldest expected entry.
   always @(negedge clk_i) begin
      if (!rst_i && result_valid_o && result_ready_i) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 1'b1, 1'b0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result_id", XLEN'(result_id_o), XLEN'(e.id));
            check("result_data", result_data_o, e.data);
            check("result_we", XLEN'(result_we_o), XLEN'(e.we));
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_issue(input logic [31:0] instr, input logic [ID_W-1:0] id,
                           input logic [XLEN-1:0] exp_data, input logic exp_acc, input logic track);
      logic [NR_ACC-1:0] ev;
      int c;
      issue_valid_i = 1'b1;
      issue_instr_i = instr;
      issue_id_i    = id;
      issue_rs1_i   = XLEN'(id) + 64'h100;
      issue_rs2_i   = XLEN'(id) + 64'h200;
      #1;
      c = 0;
      while (!issue_ready_o && c < 50) begin
         tick();
         c++;
      end
      check("issue_ready", XLEN'(issue_ready_o), 1);
      check("issue_accept", XLEN'(issue_accept_o), XLEN'(exp_acc));
      ev = '0;
      if (exp_acc) ev[instr[13:12]] = 1'b1;
      check("acc_req_valid", XLEN'(acc_req_valid_o), XLEN'(ev));
      if (exp_acc && track) sb.push_back('{id: id, data: exp_data, we: (instr[11:7] != 5'd0)});
      tick();
      issue_valid_i = 1'b0;
   endtask

   task automatic respond(input int l, input logic [XLEN-1:0] d);
      acc_resp_valid_i[l]            = 1'b1;
      acc_resp_data_i[l*XLEN +: XLEN] = d;
      tick();
      acc_resp_valid_i = '0;
   endtask

   initial begin
      int c;
      rst_i = 1'b1; issue_valid_i = 1'b0; issue_instr_i = '0; issue_rs1_i = '0; issue_rs2_i = '0;
      issue_id_i = '0; acc_req_ready_i = '1; acc_resp_valid_i = '0; acc_resp_data_i = '0;
      result_ready_i = 1'b1; flush_i = 1'b0;
      tick(); tick();
      rst_i = 1'b0;
      check("reset_result_valid", XLEN'(result_valid_o), 0);
      check("reset_busy", XLEN'(busy_o), 0);

      // 1: single lane-1 op, lane-not-ready stall, then response latency
      acc_req_ready_i = 4'b1101;
      issue_valid_i = 1'b1; issue_instr_i = 32'h0000_150B; issue_id_i = 3'd3;
      #1;
      check("stall_lane_not_ready", XLEN'(issue_ready_o), 0);
      check("stall_req_valid", XLEN'(acc_req_valid_o), 4'b0010);
      acc_req_ready_i = '1;
      do_issue(32'h0000_150B, 3'd3, 64'hDEAD, 1'b1, 1'b1);
      check("busy_after_issue", XLEN'(busy_o), 1);
      respond(1, 64'hDEAD);
      check("latency_t1_not_valid", XLEN'(result_valid_o), 0);
      tick();
      check("latency_t2_valid", XLEN'(result_valid_o), 1);
      tick();

      // 2: rejected opcode
      do_issue(32'h0000_0033, 3'd0, 64'h0, 1'b0, 1'b0);
      check("reject_busy", XLEN'(busy_o), 0);

      // 3: out-of-order lane responses come back in order
      do_issue(32'h0000_008B, 3'd1, 64'h11, 1'b1, 1'b1);
      do_issue(32'h0000_210B, 3'd2, 64'h22, 1'b1, 1'b1);
      respond(2, 64'h22);
      tick();
      check("ooo_head_blocks", XLEN'(result_valid_o), 0);
      respond(0, 64'h11);
      tick(); tick(); tick();

      // 4: fill the ROB, full blocks accepted issues but not rejects
      do_issue(32'h0000_020B, 3'd4, 64'h40, 1'b1, 1'b1);
      do_issue(32'h0000_128B, 3'd5, 64'h41, 1'b1, 1'b1);
      do_issue(32'h0000_230B, 3'd6, 64'h42, 1'b1, 1'b1);
      do_issue(32'h0000_300B, 3'd7, 64'h43, 1'b1, 1'b1);
      issue_valid_i = 1'b1; issue_instr_i = 32'h0000_108B; issue_id_i = 3'd0;
      #1;
      check("full_ready", XLEN'(issue_ready_o), 0);
      check("full_req_valid", XLEN'(acc_req_valid_o), 0);
      issue_instr_i = 32'h0000_0033;
      #1;
      check("full_reject_ready", XLEN'(issue_ready_o), 1);
      check("full_reject_accept", XLEN'(issue_accept_o), 0);
      issue_valid_i = 1'b0;
      respond(0, 64'h40);
      tick();
      issue_valid_i = 1'b1; issue_instr_i = 32'h0000_108B;
      #1;
      check("ready_after_commit", XLEN'(issue_ready_o), 1);
      issue_valid_i = 1'b0;
      respond(1, 64'h41);
      respond(2, 64'h42);
      respond(3, 64'h43);
      tick(); tick(); tick(); tick();
      check("drain_empty", XLEN'(sb.size()), 0);

      // 5: flush with two lane-1 ops outstanding
      do_issue(32'h0000_108B, 3'd1, 64'h0, 1'b1, 1'b0);
      do_issue(32'h0000_108B, 3'd2, 64'h0, 1'b1, 1'b0);
      flush_i = 1'b1;
      issue_valid_i = 1'b1; issue_instr_i = 32'h0000_008B;
      #1;
      check("flush_blocks_issue", XLEN'(issue_ready_o), 0);
      tick();
      flush_i = 1'b0; issue_valid_i = 1'b0;
      check("flush_busy", XLEN'(busy_o), 1);
      respond(1, 64'hAA);
      check("drop1_busy", XLEN'(busy_o), 1);
      respond(1, 64'hBB);
      check("drop2_busy", XLEN'(busy_o), 0);
      tick(); tick();
      check("drop_no_result", XLEN'(result_valid_o), 0);

      // 6: backpressure, then reset mid-stream
      result_ready_i = 1'b0;
      do_issue(32'h0000_028B, 3'd5, 64'h55, 1'b1, 1'b1);
      do_issue(32'h0000_130B, 3'd6, 64'h66, 1'b1, 1'b1);
      acc_resp_valid_i = 4'b0011;
      acc_resp_data_i[0 +: XLEN]    = 64'h55;
      acc_resp_data_i[XLEN +: XLEN] = 64'h66;
      tick();
      acc_resp_valid_i = '0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", XLEN'(result_valid_o), 1);
         check("hold_id", XLEN'(result_id_o), 5);
         check("hold_data", result_data_o, 64'h55);
         tick();
      end
      result_ready_i = 1'b1;
      tick();
      check("second_valid", XLEN'(result_valid_o), 1);
      check("second_id", XLEN'(result_id_o), 6);
      tick();
      result_ready_i = 1'b0;
      do_issue(32'h0000_338B, 3'd7, 64'h77, 1'b1, 1'b1);
      respond(3, 64'h77);
      tick();
      check("pre_reset_valid", XLEN'(result_valid_o), 1);
      check("pre_reset_sb", XLEN'(sb.size()), 1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      sb.delete();
      check("rst_valid", XLEN'(result_valid_o), 0);
      check("rst_id", XLEN'(result_id_o), 0);
      check("rst_data", result_data_o, 0);
      check("rst_we", XLEN'(result_we_o), 0);
      check("rst_busy", XLEN'(busy_o), 0);
      result_ready_i = 1'b1;
      c = 0;
      while (sb.size() != 0 && c < 20) begin
         tick();
         c++;
      end
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
